// File: rtl/beamscaler_readout.sv
// Control sequencer for a two-bank SIMD beam scaler DSP cascade. Banks ping-pong
// on each period tick, and the idle bank is shifted into a wishbone-readable buffer.
module beamscaler_readout #(
  parameter int NSCALER  = 12,
  parameter int ADR_BITS = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                tick_i,
  input  logic                enable_i,
  output logic [2:0]          state_o,
  output logic [1:0]          state_ce_o,
  output logic [1:0]          dsp_ce_o,
  output logic                rstp_o,
  input  logic [95:0]         chain_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic [ADR_BITS-1:0] wb_adr_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic                done_o
);

  localparam logic [2:0] MODE_COUNT   = 3'b010;
  localparam logic [2:0] MODE_COMPUTE = 3'b111;
  localparam logic [2:0] MODE_SHIFT   = 3'b001;

  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_IDLE = 3'd1;
  localparam logic [2:0] ST_PREP = 3'd2;
  localparam logic [2:0] ST_CMP0 = 3'd3;
  localparam logic [2:0] ST_CMP1 = 3'd4;
  localparam logic [2:0] ST_DSH  = 3'd5;
  localparam logic [2:0] ST_PSH  = 3'd6;

  localparam int         SW       = (NSCALER > 1) ? $clog2(NSCALER) : 1;
  localparam logic [3:0] K_LAST   = 4'(NSCALER - 1);
  localparam logic [4:0] N_SLICES = 5'(NSCALER);

  logic [2:0]  state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic        act_q, act_d;
  logic        pending_q, pending_d;
  logic        overrun_q;
  logic [1:0]  valid_q;
  logic [15:0] seq_q;
  logic        start_ro, end_ro;

  logic [2:0]  mode_d;
  logic [1:0]  sce_d, dce_d, sel_x;
  logic        rstp_d;

  // Readout buffers: one 48-bit word (4 x 12-bit fields) per slice and bank.
  logic [47:0] buf_a [NSCALER];
  logic [47:0] buf_b [NSCALER];
  logic [3:0]  slot;
  logic        capture;

  logic        wb_req, status_rd;
  logic [3:0]  rd_slice;
  logic [47:0] rd_word;
  logic [11:0] rd_field;
  logic [31:0] rd_data;

  // Sequencer next state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    k_d      = k_q;
    act_d    = act_q;
    start_ro = 1'b0;
    end_ro   = 1'b0;
    if (!enable_i) begin
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_INIT: begin
          state_d = ST_IDLE;
          act_d   = 1'b0;
        end
        ST_IDLE: begin
          if (tick_i || pending_q) begin
            state_d  = ST_PREP;
            start_ro = 1'b1;
          end
        end
        ST_PREP: state_d = ST_CMP0;
        ST_CMP0: state_d = ST_CMP1;
        ST_CMP1: begin
          state_d = ST_DSH;
          k_d     = 4'd0;
        end
        ST_DSH:  state_d = ST_PSH;
        ST_PSH: begin
          if (k_q == K_LAST) begin
            state_d = ST_IDLE;
            act_d   = ~act_q;
            end_ro  = 1'b1;
          end else begin
            state_d = ST_DSH;
            k_d     = k_q + 4'd1;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  // A tick arriving while busy is remembered once; leaving IDLE consumes it.
  always_comb begin
    pending_d = 1'b0;
    if (enable_i && state_q != ST_IDLE) pending_d = pending_q | tick_i;
  end

  // Control outputs are decoded from the next state so they line up with it.
  always_comb begin
    sel_x  = act_d ? 2'b10 : 2'b01;
    mode_d = state_o;
    sce_d  = 2'b00;
    dce_d  = 2'b00;
    rstp_d = 1'b0;
    case (state_d)
      ST_INIT: begin mode_d = MODE_COUNT;   sce_d = 2'b11;  rstp_d = 1'b1; end
      ST_IDLE: begin mode_d = MODE_COUNT;   dce_d = sel_x;                 end
      ST_PREP: begin mode_d = MODE_COUNT;   sce_d = ~sel_x; dce_d = sel_x; end
      ST_CMP0: begin mode_d = MODE_COMPUTE; sce_d = sel_x;  dce_d = ~sel_x; end
      ST_CMP1: dce_d = 2'b11;
      ST_DSH:  begin mode_d = MODE_SHIFT;   sce_d = sel_x;  dce_d = ~sel_x; end
      ST_PSH:  dce_d = 2'b11;
      default: ;
    endcase
  end

  // First capture is the slice nearest the chain output, i.e. the highest index.
  assign slot    = K_LAST - k_q;
  assign capture = enable_i && (state_q == ST_DSH);

  // NOTE: the buffers are plain storage with no reset; valid flags say what is meaningful.
  always_ff @(posedge wb_clk_i) begin
    if (capture) begin
      if (act_q) buf_b[slot[SW-1:0]] <= chain_i[95:48];
      else       buf_a[slot[SW-1:0]] <= chain_i[47:0];
    end
  end

  assign wb_req    = wb_cyc_i && wb_stb_i && !wb_ack_o;
  assign status_rd = wb_req && wb_adr_i[7];
  assign rd_slice  = wb_adr_i[5:2];

  always_comb begin
    rd_word = 48'd0;
    if ({1'b0, rd_slice} < N_SLICES)
      rd_word = wb_adr_i[6] ? buf_b[rd_slice[SW-1:0]] : buf_a[rd_slice[SW-1:0]];
    case (wb_adr_i[1:0])
      2'd0:    rd_field = rd_word[11:0];
      2'd1:    rd_field = rd_word[23:12];
      2'd2:    rd_field = rd_word[35:24];
      default: rd_field = rd_word[47:36];
    endcase
    if (wb_adr_i[7]) rd_data = {seq_q, 13'd0, overrun_q, valid_q[1], valid_q[0]};
    else             rd_data = {20'd0, rd_field};
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_INIT;
      k_q        <= 4'd0;
      act_q      <= 1'b0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      valid_q    <= 2'b00;
      seq_q      <= 16'd0;
      state_o    <= MODE_COUNT;
      state_ce_o <= 2'b00;
      dsp_ce_o   <= 2'b00;
      rstp_o     <= 1'b1;
      done_o     <= 1'b0;
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      k_q        <= k_d;
      act_q      <= act_d;
      pending_q  <= pending_d;
      state_o    <= mode_d;
      state_ce_o <= sce_d;
      dsp_ce_o   <= dce_d;
      rstp_o     <= rstp_d;
      done_o     <= end_ro;
      if (start_ro)    valid_q[act_q] <= 1'b0;
      else if (end_ro) valid_q[act_q] <= 1'b1;
      if (end_ro) seq_q <= seq_q + 16'd1;
      // A new overrun in the same cycle as a status read survives the clear.
      if (tick_i && pending_q) overrun_q <= 1'b1;
      else if (status_rd)      overrun_q <= 1'b0;
      wb_ack_o <= wb_req;
      if (wb_req) wb_dat_o <= rd_data;
    end
  end

endmodule

// File: tb/tb_beamscaler_readout.sv
// Self-checking bench for beamscaler_readout: directed scenarios plus a random
// phase, all compared against a cycle-level behavioural model of the readout.
module tb_beamscaler_readout;

  localparam int NS = 12;
  localparam logic [2:0] M_COUNT = 3'b010;
  localparam logic [2:0] M_COMP  = 3'b111;
  localparam logic [2:0] M_SHIFT = 3'b001;

  logic        clk = 1'b0;
  logic        rst, tick, enable, cyc, stb;
  logic [7:0]  adr;
  logic [95:0] chain;
  logic [2:0]  state_o;
  logic [1:0]  state_ce_o, dsp_ce_o;
  logic        rstp_o, wb_ack_o, done_o;
  logic [31:0] wb_dat_o;

  always #5 clk = ~clk;

  beamscaler_readout #(.NSCALER(NS), .ADR_BITS(8)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .tick_i     (tick),
    .enable_i   (enable),
    .state_o    (state_o),
    .state_ce_o (state_ce_o),
    .dsp_ce_o   (dsp_ce_o),
    .rstp_o     (rstp_o),
    .chain_i    (chain),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_adr_i   (adr),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .done_o     (done_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: phase -2 = init, -1 = idle, 0.. = cycle index within a readout.
  int          m_phase;
  bit          m_act, m_pending, m_overrun, m_done, m_ack, m_dat_known;
  bit   [1:0]  m_valid;
  int          m_seq;
  logic [31:0] m_dat;
  logic [47:0] m_buf [2][NS];
  bit          m_known [2][NS];
  int          chain_mode;

  task automatic model_read(input logic [7:0] a, output logic [31:0] d, output bit kn);
    int slice, f;
    logic [47:0] w;
    slice = int'(a[5:2]);
    f = int'(a[1:0]);
    kn = 1'b1;
    d = 32'd0;
    if (a[7]) d = {m_seq[15:0], 13'd0, m_overrun, m_valid[1], m_valid[0]};
    else if (slice < NS) begin
      kn = m_known[a[6]][slice];
      w = m_buf[a[6]][slice];
      d = {20'd0, w[f*12 +: 12]};
    end
  endtask

  task automatic model_step();
    bit req, srd, ov_set, kn;
    int k;
    logic [31:0] d;
    req = cyc && stb && !m_ack;
    if (req) begin
      model_read(adr, d, kn);
      m_dat = d;
      m_dat_known = kn;
    end
    srd = req && adr[7];
    ov_set = tick && m_pending;
    m_done = 1'b0;
    if (!enable) begin
      m_phase = -2;
      m_pending = 1'b0;
    end else if (m_phase == -2) begin
      m_phase = -1;
      m_act = 1'b0;
      m_pending = m_pending || tick;
    end else if (m_phase == -1) begin
      if (tick || m_pending) begin
        m_phase = 0;
        m_valid[m_act] = 1'b0;
      end
      m_pending = 1'b0;
    end else begin
      m_pending = m_pending || tick;
      if (m_phase >= 3) begin
        k = (m_phase - 3) / 2;
        if ((m_phase - 3) % 2 == 0) begin
          m_buf[m_act][NS-1-k] = m_act ? chain[95:48] : chain[47:0];
          m_known[m_act][NS-1-k] = 1'b1;
          m_phase++;
        end else if (k == NS - 1) begin
          m_done = 1'b1;
          m_valid[m_act] = 1'b1;
          m_seq = (m_seq + 1) % 65536;
          m_act = !m_act;
          m_phase = -1;
        end else m_phase++;
      end else m_phase++;
    end
    if (ov_set) m_overrun = 1'b1;
    else if (srd) m_overrun = 1'b0;
    m_ack = req;
  endtask

  // Expected {state_o, state_ce_o, dsp_ce_o, rstp_o, done_o}; mode is don't-care in CMP1/PSH.
  task automatic exp_ctrl(output logic [8:0] e, output bit mask_mode);
    logic [1:0] x, y;
    x = m_act ? 2'b10 : 2'b01;
    y = ~x;
    mask_mode = 1'b0;
    if (m_phase == -2)      e = {M_COUNT, 2'b11, 2'b00, 1'b1, 1'b0};
    else if (m_phase == -1) e = {M_COUNT, 2'b00, x, 1'b0, 1'b0};
    else if (m_phase == 0)  e = {M_COUNT, y, x, 1'b0, 1'b0};
    else if (m_phase == 1)  e = {M_COMP, x, y, 1'b0, 1'b0};
    else if (m_phase == 2 || (m_phase - 3) % 2 == 1) begin
      e = {3'b000, 2'b00, 2'b11, 1'b0, 1'b0};
      mask_mode = 1'b1;
    end else e = {M_SHIFT, x, y, 1'b0, 1'b0};
    e[0] = m_done;
  endtask

  // One clock: drive chain, advance the model, then compare at the next falling edge.
  task automatic step();
    logic [63:0] r1, r2;
    logic [47:0] lo, hi, pat;
    logic [8:0]  e, g;
    bit          mm;
    int          k;
    r1 = {$urandom(), $urandom()};
    r2 = {$urandom(), $urandom()};
    lo = r1[47:0];
    hi = r2[47:0];
    if (chain_mode != 0 && m_phase >= 3 && (m_phase - 3) % 2 == 0) begin
      k = (m_phase - 3) / 2;
      if (chain_mode == 1) pat = {12'(k + 3), 12'(k + 2), 12'(k + 1), 12'(k)};
      else begin
        pat = m_act ? hi : lo;
        pat[35:24] = 12'hFFF;
      end
      if (m_act) hi = pat;
      else lo = pat;
    end
    chain = {hi, lo};
    model_step();
    @(posedge clk);
    @(negedge clk);
    exp_ctrl(e, mm);
    g = {mm ? 3'b000 : state_o, state_ce_o, dsp_ce_o, rstp_o, done_o};
    check("ctrl", 64'(g), 64'(e));
    check("ack", 64'(wb_ack_o), 64'(m_ack));
    if (m_ack && m_dat_known) check("rdata", 64'(wb_dat_o), 64'(m_dat));
  endtask

  task automatic wb_read(input logic [7:0] a, output logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; adr = a;
    step();
    d = wb_dat_o;
    check("rd_ack", 64'(wb_ack_o), 64'd1);
    cyc = 1'b0; stb = 1'b0;
    step();
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!done_o && n < 200) begin
      step();
      n++;
    end
    check(tag, 64'(done_o), 64'd1);
  endtask

  logic [31:0] d;
  logic [3:0]  acks;
  int          n;

  initial begin
    rst = 1'b1; tick = 1'b0; enable = 1'b0; cyc = 1'b0; stb = 1'b0; adr = 8'd0;
    chain = 96'd0; chain_mode = 0;
    m_phase = -2; m_act = 1'b0; m_pending = 1'b0; m_overrun = 1'b0; m_done = 1'b0;
    m_ack = 1'b0; m_dat_known = 1'b0; m_valid = 2'b00; m_seq = 0; m_dat = 32'd0;
    for (int b = 0; b < 2; b++)
      for (int s = 0; s < NS; s++) begin
        m_known[b][s] = 1'b0;
        m_buf[b][s] = 48'd0;
      end
    #3;
    check("rst_state", 64'(state_o), 64'(M_COUNT));
    check("rst_state_ce", 64'(state_ce_o), 64'd0);
    check("rst_dsp_ce", 64'(dsp_ce_o), 64'd0);
    check("rst_rstp", 64'(rstp_o), 64'd1);
    check("rst_ack", 64'(wb_ack_o), 64'd0);
    check("rst_dat", 64'(wb_dat_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) step();
    enable = 1'b1;
    repeat (3) step();

    // Bank A readout with the counting pattern.
    chain_mode = 1;
    tick = 1'b1; step(); tick = 1'b0;
    wait_done("done_a", n);
    check("done_latency", 64'(n), 64'd27);
    wb_read(8'h2C, d); check("a_s11_f0", 64'(d), 64'h000);
    wb_read(8'h03, d); check("a_s0_f3", 64'(d), 64'h00E);
    wb_read(8'h80, d); check("status_1", 64'(d), 64'h0001_0001);

    // Bank B readout with saturated field 2.
    chain_mode = 2;
    tick = 1'b1; step(); tick = 1'b0;
    wait_done("done_b", n);
    check("done_latency_b", 64'(n), 64'd27);
    wb_read(8'h80, d); check("status_2", 64'(d), 64'h0002_0003);
    wb_read(8'h56, d); check("b_sat", 64'(d), 64'h0000_0FFF);
    chain_mode = 0;

    // Pending tick then overrun during one readout.
    tick = 1'b1; step(); tick = 1'b0;
    for (int i = 1; i <= 27; i++) begin
      tick = (i == 6 || i == 10);
      step();
    end
    tick = 1'b0;
    check("pend_done", 64'(done_o), 64'd1);
    step();
    check("restart_prep", 64'({state_ce_o, dsp_ce_o}), 64'b0110);
    wait_done("done_restart", n);
    wb_read(8'h80, d); check("overrun_set", 64'(d[2]), 64'd1);
    wb_read(8'h80, d); check("overrun_clr", 64'(d[2]), 64'd0);

    // Disable in the middle of shifting k=4 out of bank A.
    tick = 1'b1; step(); tick = 1'b0;
    repeat (11) step();
    check("at_dsh_k4", 64'(state_o), 64'(M_SHIFT));
    enable = 1'b0; step();
    check("dis_rstp", 64'(rstp_o), 64'd1);
    check("dis_ctrl", 64'({state_ce_o, dsp_ce_o}), 64'b1100);
    step();
    enable = 1'b1; step();
    check("reen_idle_a", 64'(dsp_ce_o), 64'b01);
    wb_read(8'h80, d); check("reen_valid", 64'(d[1:0]), 64'b10);

    // Strobe held for four cycles, slice beyond the cascade reads zero.
    cyc = 1'b1; stb = 1'b1; adr = 8'h34;
    for (int i = 0; i < 4; i++) begin
      step();
      acks[3-i] = wb_ack_o;
      if (wb_ack_o) check("slice13", 64'(wb_dat_o), 64'd0);
    end
    check("ack_hold", 64'(acks), 64'b1010);
    cyc = 1'b0; stb = 1'b0;
    step();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      tick   = ($urandom_range(0, 29) == 0);
      enable = ($urandom_range(0, 199) != 0);
      cyc    = ($urandom_range(0, 2) == 0);
      stb    = cyc;
      adr    = 8'($urandom_range(0, 255));
      step();
    end
    tick = 1'b0; enable = 1'b1; cyc = 1'b0; stb = 1'b0;
    repeat (40) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/beamscaler_readout.md
Name: beamscaler_readout

Overview:
- Control and readout end of the beam scaler DSP chain.
- Generates the per-bank control (state / state_ce / dsp_ce / rstp) for a cascade of NSCALER two-bank 12-bit SIMD scaler slices, and ping-pongs counting between bank A and bank B on each period tick.
- While one bank counts, the idle bank is saturation-fixed and shifted out through the chain end. Each 4x12-bit word is captured into a double-buffered RAM readable over a read-only wishbone slave.

Parameters:
- NSCALER, 12, number of scaler slices in the PCOUT cascade. Range 1..16.
- ADR_BITS, 8, wishbone address width.

Ports:
- wb_clk_i  in  1  wishbone/DSP clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- tick_i  in  1  period tick, one-cycle pulse (ifclk CE already transferred to wb_clk).
- enable_i  in  1  0 = hold chain in reset and FSM in INIT.
- state_o  out  3  DSP mode: 010 COUNT, 111 COMPUTE (saturate), 001 SHIFT.
- state_ce_o  out  2  control-register enable: [0] bank A, [1] bank B.
- dsp_ce_o  out  2  P-register enable per bank.
- rstp_o  out  1  DSP P/control reset.
- chain_i  in  96  P output of the last slice: [47:0] bank A, [95:48] bank B.
- wb_cyc_i, wb_stb_i  in  1  wishbone cycle and strobe.
- wb_adr_i  in  ADR_BITS  read address.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  acknowledge.
- done_o  out  1  one-cycle pulse when a bank readout completes.

Behaviour:
Reset values (async): state_o=010, state_ce_o=00, dsp_ce_o=00, rstp_o=1, wb_ack_o=0, wb_dat_o=0, done_o=0. Flags cleared: valid_A, valid_B, overrun, pending. seq=0. act (counting bank)=A.

Outputs are registered from the state. In the table below, X = act and Y = !act.

FSM (state / state_o / state_ce_o / dsp_ce_o):
- INIT: COUNT / 11 / 00. rstp_o = !enable_i. Leaves to IDLE (act=A) on the first cycle with enable_i=1.
- IDLE: state_o don't-care (hold 010) / 00 / X. Bank X accumulates. Goes to PREP on tick_i or pending. Clear pending on exit.
- PREP: COUNT / Y / X.
- CMP0: COMPUTE / X / Y. Bank Y begins counting here.
- CMP1: don't-care / 00 / 11. Bank X P <= C | P, so saturated fields read 0xFFF.
- DSH: SHIFT / X / Y.
  - Capture chain_i bank X into buf[X][NSCALER-1-k], where k = capture index 0..NSCALER-1.
  - First capture is the slice nearest the output.
- PSH: don't-care / 00 / 11. Bank X P <= PCIN; a zero enters the chain head.
  - If k < NSCALER-1: go to DSH.
  - Else: set valid[X], pulse done_o, seq<=seq+1 (16-bit wrap), act<=Y, go to IDLE.

Cycle and chain rules:
- Exactly NSCALER captures and NSCALER shifts per readout, so the read bank is left all-zero.
- Readout length = 3 + 2*NSCALER cycles (27 for NSCALER=12).
- valid[X] is cleared on entering PREP and stays 0 while that bank is being rewritten.

Tick handling:
- tick_i outside IDLE sets pending.
- tick_i while pending=1 sets sticky overrun; the extra tick is dropped.
- tick_i in the same cycle as the IDLE->PREP transition is consumed as the current tick.

enable_i:
- enable_i=0 in any state gives INIT next cycle with rstp_o=1.
- Buffers and valid flags are untouched; pending is cleared.

Wishbone:
- Read-only; writes are acked and ignored.
- On cyc&stb with ack=0: wb_ack_o=1 next cycle with data. Ack is low for at least one cycle between acks.
- Address map, adr[7]=0: adr[6]=bank (0=A), adr[5:2]=slice, adr[1:0]=field.
  - Data = {20'b0, buf[bank][slice][field*12 +: 12]}.
  - slice >= NSCALER reads 0.
- adr[7]=1: status = {seq[15:0], 13'b0, overrun, valid_B, valid_A}.
  - Reading status clears overrun.
  - If a set and a clear of overrun occur in the same cycle, set wins.

Test Plan:
- Reset, enable_i=1, drive chain_i bank A field pattern per capture k: {k+3,k+2,k+1,k}, tick_i once -> exact control sequence per FSM table, done_o 27 cycles after PREP, slice 11 field 0 = 0x000, slice 0 field 3 = 0x00E, status = {1,...,valid_A=1}.
- Second tick -> bank B read with dsp_ce_o[0] high during its shifts, act returns to A, seq=2, valid_B=1, valid_A remains 1.
- Model CMP1 saturation by driving 0xFFF in field 2 -> read returns 0x00000FFF.
- Ticks at PREP+5 and PREP+9 -> first sets pending and readout restarts immediately after done, second sets overrun; status read shows overrun=1, next status read overrun=0.
- enable_i=0 mid-shift (k=4) -> next cycle INIT, rstp_o=1. Re-enable -> IDLE act=A, valid flags unchanged except the interrupted bank's valid=0.
- wb stb held 4 cycles -> acks on cycles 2 and 4 only; write cycle acked, buffer unchanged; adr slice 13 -> 0.
